// File: rtl/pipeline_pkg.sv
// Shared pipeline types: scoreboard FSM encoding and register-file geometry.
package pipeline_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      HAZARD  = 2'd1,
      MEMWAIT = 2'd2
   } sb_state_t;
endpackage

// File: rtl/sb_busy_array.sv
// Per-register load-in-flight bits plus an outstanding-load counter; updates one cycle after set/clear.
// Set and clear on the same register leave it busy; x0 is never marked busy.
module sb_busy_array
   import pipeline_pkg::*;
#(
   parameter int MAX_PEND = 7,
   parameter int CNT_W    = $clog2(MAX_PEND + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_set,
   input  logic [REG_ADDR_W-1:0] i_set_addr,
   input  logic                  i_clr,
   input  logic [REG_ADDR_W-1:0] i_clr_addr,
   output logic [NUM_REGS-1:0]   o_busy_vec,
   output logic [CNT_W-1:0]      o_pending_cnt
);

   logic [NUM_REGS-1:0] r_busy;
   logic [NUM_REGS-1:0] w_busy_nxt;
   logic [CNT_W-1:0]    r_cnt;

   always_comb begin
      w_busy_nxt = r_busy;
      if (i_clr) w_busy_nxt[i_clr_addr] = 1'b0;
      if (i_set) w_busy_nxt[i_set_addr] = 1'b1;
      w_busy_nxt[0] = 1'b0;
   end

   // Counter is bounded both ways so a stray clear after reset cannot wrap it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= '0;
         r_cnt  <= '0;
      end else begin
         r_busy <= w_busy_nxt;
         if (i_set && !i_clr && r_cnt != CNT_W'(MAX_PEND))
            r_cnt <= r_cnt + 1'b1;
         else if (i_clr && !i_set && r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_busy_vec    = r_busy;
   assign o_pending_cnt = r_cnt;

endmodule

// File: rtl/reg_scoreboard.sv
// Load-use scoreboard: combinational stall/bubble from registered busy bits, registered FSM and stall counter.
// mem_wait freezes everything and outranks ex_flush, which outranks a detected hazard.
module reg_scoreboard
   import pipeline_pkg::*;
#(
   parameter int MAX_PEND    = 7,
   parameter int STALL_CNT_W = 16
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            id_valid,
   input  logic [4:0]                      id_rs1,
   input  logic [4:0]                      id_rs2,
   input  logic                            id_rs1_used,
   input  logic                            id_rs2_used,
   input  logic [4:0]                      id_rd,
   input  logic                            id_RegWEn,
   input  logic                            id_MemRead,
   input  logic [4:0]                      mem_rd,
   input  logic                            mem_RegWEn,
   input  logic                            mem_MemRead,
   input  logic                            mem_wait,
   input  logic                            ex_flush,
   output logic                            stall,
   output logic                            bubble,
   output logic [31:0]                     busy_vec,
   output logic [$clog2(MAX_PEND+1)-1:0]   pending_cnt,
   output logic [1:0]                      fsm_state,
   output logic [STALL_CNT_W-1:0]          stall_cycles
);

   localparam int CNT_W = $clog2(MAX_PEND + 1);

   logic                 w_ld_issue;
   logic                 w_ld_done;
   logic [NUM_REGS-1:0]  w_clr_mask;
   logic [NUM_REGS-1:0]  w_eb;
   logic                 w_raw;
   logic                 w_waw;
   logic                 w_full;
   logic                 w_hazard;
   sb_state_t            r_state;
   sb_state_t            w_state_nxt;
   logic [STALL_CNT_W-1:0] r_stall_cycles;

   assign w_ld_done = mem_MemRead & mem_RegWEn & (mem_rd != 5'd0) & ~mem_wait;
   assign w_ld_issue = id_valid & id_MemRead & id_RegWEn & (id_rd != 5'd0)
                     & ~stall & ~ex_flush & ~mem_wait;

   // A load completing this cycle forwards from WB next cycle, so its bit is not a hazard.
   assign w_clr_mask = w_ld_done ? (NUM_REGS'(1) << mem_rd) : '0;
   assign w_eb       = busy_vec & ~w_clr_mask;

   assign w_raw  = id_valid & ((id_rs1_used & (id_rs1 != 5'd0) & w_eb[id_rs1])
                             | (id_rs2_used & (id_rs2 != 5'd0) & w_eb[id_rs2]));
   assign w_waw  = id_valid & id_RegWEn & (id_rd != 5'd0) & w_eb[id_rd];
   assign w_full = id_valid & id_MemRead & (pending_cnt == CNT_W'(MAX_PEND)) & ~w_ld_done;
   assign w_hazard = w_raw | w_waw | w_full;

   always_comb begin
      stall  = 1'b0;
      bubble = 1'b0;
      if (mem_wait) begin
         stall = 1'b1;
      end else if (ex_flush) begin
         stall = 1'b0;
      end else if (w_hazard) begin
         stall  = 1'b1;
         bubble = 1'b1;
      end
   end

   sb_busy_array #(
      .MAX_PEND (MAX_PEND),
      .CNT_W    (CNT_W)
   ) u_busy (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_set         (w_ld_issue),
      .i_set_addr    (id_rd),
      .i_clr         (w_ld_done),
      .i_clr_addr    (mem_rd),
      .o_busy_vec    (busy_vec),
      .o_pending_cnt (pending_cnt)
   );

   always_comb begin
      w_state_nxt = RUN;
      if (mem_wait)
         w_state_nxt = MEMWAIT;
      else if (w_hazard && !ex_flush)
         w_state_nxt = HAZARD;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= RUN;
         r_stall_cycles <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (stall && r_stall_cycles != '1)
            r_stall_cycles <= r_stall_cycles + 1'b1;
      end
   end

   assign fsm_state    = r_state;
   assign stall_cycles = r_stall_cycles;

endmodule
